matrix_operand_loader: RTL
==========================

Name: matrix_operand_loader

Overview:
- Upstream feeder for the square matrix multiplier.
- Accepts operand vectors over a narrow valid/ready stream and assembles one full A matrix (row-major) plus one full B matrix (column-major) into flat SIZE*SIZE*DATA_WIDTH buses.
- The flat buses drive the multiplier's data0_in/data1_in inputs.
- Double-buffered (ping-pong): the next operand pair loads while the current pair is held for the consumer.

Parameters:
- DATA_WIDTH, 32, bits per matrix element.
- SIZE, 4, matrix dimension; vector = SIZE elements, matrix = SIZE*SIZE elements.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- clr  in  1  synchronous flush: discards partial fill and both banks.
- in_valid  in  1  source has a vector beat.
- in_ready  out  1  loader can accept a beat.
- in_data  in  DATA_WIDTH*SIZE  one vector; element e at bits [DW*(e+1)-1 : DW*e].
- out_valid  out  1  a complete A/B pair is presented.
- out_ready  in  1  consumer takes the pair.
- mat_a  out  DATA_WIDTH*SIZE*SIZE  A row i at bits [DW*SIZE*(i+1)-1 : DW*SIZE*i].
- mat_b  out  DATA_WIDTH*SIZE*SIZE  B column j at bits [DW*SIZE*(j+1)-1 : DW*SIZE*j].

Behaviour:
- Transfer rules:
  - A beat transfers when in_valid && in_ready.
  - A pair is consumed when out_valid && out_ready.
- Beat order per pair: 2*SIZE beats.
  - Beats 0..SIZE-1 are A rows 0..SIZE-1.
  - Beats SIZE..2*SIZE-1 are B vectors 0..SIZE-1.
- Beat counter beat_cnt:
  - Width $clog2(2*SIZE).
  - Increments per accepted beat and wraps to 0 after beat 2*SIZE-1.
- Two banks, each with state EMPTY, FILLING or FULL. Pointers wr_bank and rd_bank.
- Bank state transitions:
  - EMPTY -> FILLING on the first accepted beat.
  - FILLING -> FULL on the accepted beat 2*SIZE-1; wr_bank toggles.
  - FULL -> EMPTY on consume; rd_bank toggles.
- in_ready = bank[wr_bank] != FULL (combinational from registered state).
- out_valid = bank[rd_bank] == FULL (registered state).
- mat_a/mat_b are muxed from bank[rd_bank] and are stable while out_valid && !out_ready.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t; visible in cycle t+1.
- Throughput: one pair per 2*SIZE cycles with in_valid and out_ready held high. No bubbles on bank swap.
- Simultaneous fill-complete and consume in the same cycle: both legal, since they target different banks. After the edge, the freshly filled bank is FULL and the consumed bank is EMPTY.
- Both banks FULL: in_ready=0 and beats stall. Beat data is ignored when in_ready=0.
- clr:
  - Synchronous and dominant over any same-cycle transfer.
  - Sets both banks EMPTY, wr_bank=rd_bank=0, beat_cnt=0.
  - Bank storage is not cleared.
- rst (async, low): same effect as clr, plus bank storage and mat_a/mat_b = 0.
- Reset output values: out_valid=0, in_ready=1, mat_a=0, mat_b=0.
- Reset mid-fill: the partial pair is lost. The next accepted beat is A row 0.

Optional Feature:
- Macro: MATRIX_LOADER_TRANSPOSE_B_EN
- Defined: B beats carry B rows (row-major).
  - B beat k, element j is written to column j, element k.
  - Destination: mat_b bits [DW*(SIZE*j+k+1)-1 : DW*(SIZE*j+k)].
- Undefined: B beat k is column k and is stored directly at mat_b bits [DW*SIZE*(k+1)-1 : DW*SIZE*k].
- A handling is identical in both builds.

Decomposition:
- Package gemm_pkg contains:
  - DATA_WIDTH and SIZE defaults.
  - Localparams VEC_W = DATA_WIDTH*SIZE and MAT_W = VEC_W*SIZE.
  - Typedef bank_state_t enum {EMPTY, FILLING, FULL}.
- Sub-module operand_bank:
  - Holds one A/B storage pair and its bank_state_t.
  - Inputs: write strobe, beat index, in_data, mark_full, consume, clr.
  - Instantiated twice by the loader.
  - The transpose macro is handled inside operand_bank's B write path.

Test Plan:
- Reset release, no traffic -> out_valid=0, in_ready=1, mat_a=mat_b=0.
- Fill A rows with element values 0..15 in row-major order, then B columns with 16..31, out_ready=1 -> out_valid high one cycle after beat 7; mat_a[31:0]=0, mat_a[511:480]=15, mat_b[31:0]=16, mat_b[511:480]=31; consumed in the same cycle.
- out_ready=0, stream three pairs back-to-back -> in_ready drops after pair 2's last beat; mat_a/mat_b hold pair 1 unchanged; raising out_ready delivers pairs 1,2,3 in order with no loss.
- Continuous streaming with out_ready=1 -> one pair every 8 cycles, no in_ready deassertion.
- clr after 5 beats, then a full new pair -> only the new pair appears; its A row 0 equals the first post-clr beat.
- MATRIX_LOADER_TRANSPOSE_B_EN defined, B beat 0 = {4,3,2,1} (element0 = 1) -> mat_b element index SIZE*j+0 equals j+1 for j=0..3, i.e. mat_b[31:0]=1, mat_b[159:128]=2.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared defaults, derived widths and the bank state type for the matrix operand loader
package gemm_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int SIZE = 4;
  localparam int VEC_W = DATA_WIDTH * SIZE;
  localparam int MAT_W = VEC_W * SIZE;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
endpackage

// File: rtl/operand_bank.sv
// operand_bank: one A/B storage pair plus its fill state; MATRIX_LOADER_TRANSPOSE_B_EN makes B beats rows instead of columns
module operand_bank #(
  parameter int DATA_WIDTH = gemm_pkg::DATA_WIDTH,
  parameter int SIZE = gemm_pkg::SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic we,
  input  logic [$clog2(2*SIZE)-1:0] idx,
  input  logic [DATA_WIDTH*SIZE-1:0] din,
  input  logic mark_full,
  input  logic consume,
  output gemm_pkg::bank_state_t state,
  output logic [DATA_WIDTH*SIZE*SIZE-1:0] a,
  output logic [DATA_WIDTH*SIZE*SIZE-1:0] b
);
  import gemm_pkg::*;
  localparam int DW = DATA_WIDTH;
  localparam int VW = DATA_WIDTH * SIZE;
  localparam int MW = VW * SIZE;
  localparam int CW = $clog2(2 * SIZE);
  bank_state_t state_d, state_q;
  logic [MW-1:0] a_d, a_q, b_d, b_q;
  logic [CW-1:0] k;
  // bank lifecycle: flush and consume empty it, the last beat fills it, the first beat starts it
  always_comb state_d = clr ? EMPTY : consume ? EMPTY : mark_full ? FULL :
                        (we && state_q == EMPTY) ? FILLING : state_q;
  // beats below SIZE are A rows; the rest land in B as columns, or scattered as rows when transposing
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    k = idx - CW'(SIZE);
    if (we && idx < CW'(SIZE)) a_d[VW*idx +: VW] = din;
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    if (we && idx >= CW'(SIZE))
      for (int j = 0; j < SIZE; j++) b_d[DW*(SIZE*j+int'(k)) +: DW] = din[DW*j +: DW];
`else
    if (we && idx >= CW'(SIZE)) b_d[VW*k +: VW] = din;
`endif
  end
  // state and storage registers; only reset clears storage, flush leaves it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= EMPTY;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  assign state = state_q;
  assign a = a_q;
  assign b = b_q;
endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: ping-pong assembler of A (row-major) / B matrix pairs from a vector stream; see MATRIX_LOADER_TRANSPOSE_B_EN in operand_bank
module matrix_operand_loader #(
  parameter int DATA_WIDTH = gemm_pkg::DATA_WIDTH,
  parameter int SIZE = gemm_pkg::SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH*SIZE-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_WIDTH*SIZE*SIZE-1:0] mat_a,
  output logic [DATA_WIDTH*SIZE*SIZE-1:0] mat_b
);
  import gemm_pkg::*;
  localparam int MW = DATA_WIDTH * SIZE * SIZE;
  localparam int CW = $clog2(2 * SIZE);
  bank_state_t st [2];
  logic [MW-1:0] ba [2];
  logic [MW-1:0] bb [2];
  logic [CW-1:0] beat_cnt_d, beat_cnt_q;
  logic wr_bank_d, wr_bank_q, rd_bank_d, rd_bank_q;
  logic acc, last, cons;
  // handshakes come from registered bank state; flush suppresses both transfers
  always_comb begin
    in_ready = st[wr_bank_q] != FULL;
    out_valid = st[rd_bank_q] == FULL;
    acc = in_valid && in_ready && !clr;
    cons = out_valid && out_ready && !clr;
    last = acc && beat_cnt_q == CW'(2*SIZE-1);
    beat_cnt_d = (clr || last) ? '0 : acc ? beat_cnt_q + 1'b1 : beat_cnt_q;
    wr_bank_d = clr ? 1'b0 : wr_bank_q ^ last;
    rd_bank_d = clr ? 1'b0 : rd_bank_q ^ cons;
    mat_a = ba[rd_bank_q];
    mat_b = bb[rd_bank_q];
  end
  // beat counter and bank pointers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  for (genvar i = 0; i < 2; i++) begin : g_bank
    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) u_bank (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .we(acc && wr_bank_q == 1'(i)),
      .idx(beat_cnt_q),
      .din(in_data),
      .mark_full(last && wr_bank_q == 1'(i)),
      .consume(cons && rd_bank_q == 1'(i)),
      .state(st[i]),
      .a(ba[i]),
      .b(bb[i])
    );
  end
endmodule
